// File: rtl/pulse_layer_pkg.sv
// ----------------------------------------------------------------------------
// pulse_layer_pkg
//   Shared types and default sizes for the pulse-layer sequencer.
//   - top_state_e   : shot-level FSM (IDLE / ARMED / RUNNING / DONE)
//   - layer_state_e : per-layer pulse FSM (IDLE / RUN / END)
//   - DEF_*         : default layer count and counter widths
// ----------------------------------------------------------------------------
package pulse_layer_pkg;

   localparam int DEF_N_LAYERS = 8;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_REP_W    = 8;

   typedef enum logic [1:0] {
      TOP_IDLE    = 2'd0,
      TOP_ARMED   = 2'd1,
      TOP_RUNNING = 2'd2,
      TOP_DONE    = 2'd3
   } top_state_e;

   typedef enum logic [1:0] {
      LAYER_IDLE = 2'd0,
      LAYER_RUN  = 2'd1,
      LAYER_END  = 2'd2
   } layer_state_e;

endpackage

// File: rtl/pulse_layer_unit.sv
// ----------------------------------------------------------------------------
// pulse_layer_unit
//   One layer of the sequencer: pulse FSM, pulse-width down-counter,
//   saturating fire counter, registered LayerLast and sticky overrun flag.
//
// Ports
//   clock, reset   : clock, synchronous active-high reset
//   clear_i        : shot arm; clears fire count, LayerLast and overrun
//   abort_i        : forced stop; layer to IDLE, LayerLast and count cleared
//   enable_i       : top FSM is ARMED or RUNNING
//   mask_i         : layer participates in the shot (shadow copy)
//   width_i        : pulse width in cycles, 0 treated as 1 (shadow copy)
//   repeat_i       : firings before LayerLast, 0 = unlimited (shadow copy)
//   pulse_en_i     : fire request from the switch matrix
//   accept_o       : fire request accepted this cycle
//   active_o       : layer pulse high (RUN)
//   end_o          : one-cycle end-of-pulse strobe (END)
//   last_o         : repeat count reached
//   overrun_o      : sticky, fire request arrived during RUN
//   busy_o         : layer in RUN or END
// ----------------------------------------------------------------------------
module pulse_layer_unit
   import pulse_layer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             abort_i,
   input  logic             enable_i,
   input  logic             mask_i,
   input  logic [CNT_W-1:0] width_i,
   input  logic [REP_W-1:0] repeat_i,
   input  logic             pulse_en_i,
   output logic             accept_o,
   output logic             active_o,
   output logic             end_o,
   output logic             last_o,
   output logic             overrun_o,
   output logic             busy_o
);

   layer_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [REP_W-1:0] fire_q, fire_d, fire_inc;
   logic             last_q, last_d;
   logic             ovr_q, ovr_d;
   logic             eligible, accept, finishing;

   assign eligible  = enable_i && mask_i && pulse_en_i;
   assign accept    = eligible && !last_q && (state_q != LAYER_RUN);
   // The counter reads 1 in the last active cycle; <= guards a stray 0.
   assign finishing = (state_q == LAYER_RUN) && (cnt_q <= CNT_W'(1));
   assign fire_inc  = (fire_q == '1) ? fire_q : fire_q + REP_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = fire_q;
      last_d  = last_q;
      ovr_d   = ovr_q;

      case (state_q)
         LAYER_IDLE: if (accept) state_d = LAYER_RUN;
         LAYER_RUN:  if (finishing) state_d = LAYER_END;
         LAYER_END:  state_d = accept ? LAYER_RUN : LAYER_IDLE;
         default:    state_d = LAYER_IDLE;
      endcase

      if (accept) begin
         cnt_d = (width_i == '0) ? CNT_W'(1) : width_i;
      end else if (state_q == LAYER_RUN) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      // Count the firing on the RUN->END edge so LayerLast is already
      // high during the final END cycle and blocks a chained re-accept.
      if (finishing) begin
         fire_d = fire_inc;
         last_d = (repeat_i != '0) && (fire_inc >= repeat_i);
      end

      if (eligible && (state_q == LAYER_RUN)) ovr_d = 1'b1;

      if (clear_i) begin
         fire_d = '0;
         last_d = 1'b0;
         ovr_d  = 1'b0;
      end

      // Abort truncates the pulse silently; overrun survives it.
      if (abort_i) begin
         state_d = LAYER_IDLE;
         cnt_d   = '0;
         fire_d  = '0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LAYER_IDLE;
         cnt_q   <= '0;
         fire_q  <= '0;
         last_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
         last_q  <= last_d;
         ovr_q   <= ovr_d;
      end
   end

   assign accept_o  = accept;
   assign active_o  = (state_q == LAYER_RUN);
   assign end_o     = (state_q == LAYER_END);
   assign busy_o    = (state_q == LAYER_RUN) || (state_q == LAYER_END);
   assign last_o    = last_q;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/pulse_layer_ctrl.sv
// ----------------------------------------------------------------------------
// pulse_layer_ctrl
//   Shot sequencer for the pulse-layer switch matrix. Owns the
//   arm / run / done / abort FSM, shadows the shot configuration on arm and
//   instantiates one pulse_layer_unit per layer.
//
// Ports
//   clock, reset    : clock, synchronous active-high reset
//   io_arm          : start a shot (accepted in IDLE or DONE)
//   io_abort        : forced stop, highest priority
//   io_layerMask    : participating layers
//   io_width        : per-layer pulse width, CNT_W bits per layer
//   io_repeat       : per-layer repeat count, REP_W bits per layer
//   io_pulseEn      : per-layer fire request from the matrix
//   io_layerActive  : per-layer pulse
//   io_LayerEnd     : per-layer end-of-pulse strobe
//   io_LayerLast    : per-layer repeat count reached
//   io_busy         : shot ARMED or RUNNING
//   io_done         : one-cycle shot-complete strobe
//   io_overrun      : sticky per-layer overrun
//   io_wdLimit      : (watchdog build) idle-cycle limit in RUNNING, 0 = off
//   io_wdFault      : (watchdog build) sticky watchdog abort flag
//
// Build option
//   PULSE_LAYER_CTRL_WATCHDOG_EN : adds the idle watchdog and its two ports.
// ----------------------------------------------------------------------------
module pulse_layer_ctrl
   import pulse_layer_pkg::*;
#(
   parameter int N_LAYERS = DEF_N_LAYERS,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int REP_W    = DEF_REP_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_arm,
   input  logic                      io_abort,
   input  logic [N_LAYERS-1:0]       io_layerMask,
   input  logic [N_LAYERS*CNT_W-1:0] io_width,
   input  logic [N_LAYERS*REP_W-1:0] io_repeat,
   input  logic [N_LAYERS-1:0]       io_pulseEn,
   output logic [N_LAYERS-1:0]       io_layerActive,
   output logic [N_LAYERS-1:0]       io_LayerEnd,
   output logic [N_LAYERS-1:0]       io_LayerLast,
   output logic                      io_busy,
   output logic                      io_done,
   output logic [N_LAYERS-1:0]       io_overrun
`ifdef PULSE_LAYER_CTRL_WATCHDOG_EN
   ,
   input  logic [CNT_W-1:0]          io_wdLimit,
   output logic                      io_wdFault
`endif
);

   top_state_e                state_q, state_d;
   logic                      done_q, done_d;
   logic [N_LAYERS-1:0]       mask_q;
   logic [N_LAYERS*CNT_W-1:0] width_q;
   logic [N_LAYERS*REP_W-1:0] repeat_q;

   logic                      arm_ok, abort_all, enable, wd_trip;
   logic                      any_counted, all_finished, complete;
   logic [N_LAYERS-1:0]       accept_vec, active_vec, end_vec, last_vec;
   logic [N_LAYERS-1:0]       ovr_vec, busy_vec;

   assign enable    = (state_q == TOP_ARMED) || (state_q == TOP_RUNNING);
   assign abort_all = io_abort || wd_trip;
   assign arm_ok    = io_arm && !abort_all &&
                      ((state_q == TOP_IDLE) || (state_q == TOP_DONE));

   // Shadow configuration: mid-shot input changes have no effect.
   always_ff @(posedge clock) begin
      if (reset) begin
         mask_q   <= '0;
         width_q  <= '0;
         repeat_q <= '0;
      end else if (arm_ok) begin
         mask_q   <= io_layerMask;
         width_q  <= io_width;
         repeat_q <= io_repeat;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
         pulse_layer_unit #(
            .CNT_W (CNT_W),
            .REP_W (REP_W)
         ) u_unit (
            .clock      (clock),
            .reset      (reset),
            .clear_i    (arm_ok),
            .abort_i    (abort_all),
            .enable_i   (enable),
            .mask_i     (mask_q[gi]),
            .width_i    (width_q[gi*CNT_W +: CNT_W]),
            .repeat_i   (repeat_q[gi*REP_W +: REP_W]),
            .pulse_en_i (io_pulseEn[gi]),
            .accept_o   (accept_vec[gi]),
            .active_o   (active_vec[gi]),
            .end_o      (end_vec[gi]),
            .last_o     (last_vec[gi]),
            .overrun_o  (ovr_vec[gi]),
            .busy_o     (busy_vec[gi])
         );
      end
   endgenerate

   // Completion needs at least one counted layer; a shot whose masked
   // layers are all unlimited never completes.
   always_comb begin
      any_counted  = 1'b0;
      all_finished = 1'b1;
      for (int i = 0; i < N_LAYERS; i++) begin
         if (mask_q[i] && (repeat_q[i*REP_W +: REP_W] != '0)) begin
            any_counted = 1'b1;
            if (!last_vec[i] || active_vec[i]) all_finished = 1'b0;
         end
      end
   end
   assign complete = any_counted && all_finished;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         TOP_IDLE:    if (arm_ok) state_d = TOP_ARMED;
         TOP_ARMED:   if (|accept_vec) state_d = TOP_RUNNING;
         TOP_RUNNING: begin
            if (complete) begin
               state_d = TOP_DONE;
               done_d  = 1'b1;
            end
         end
         TOP_DONE:    if (arm_ok) state_d = TOP_ARMED;
         default:     state_d = TOP_IDLE;
      endcase
      if (abort_all) begin
         state_d = TOP_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= TOP_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

`ifdef PULSE_LAYER_CTRL_WATCHDOG_EN
   // Counts consecutive RUNNING cycles with no layer in RUN or END; trips
   // in the cycle that is the io_wdLimit-th such idle cycle.
   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             wd_fault_q, wd_fault_d;
   logic             wd_idle;

   assign wd_idle = (state_q == TOP_RUNNING) && !(|busy_vec);
   assign wd_trip = wd_idle && (io_wdLimit != '0) &&
                    ({1'b0, wd_cnt_q} + {{CNT_W{1'b0}}, 1'b1} >= {1'b0, io_wdLimit});

   always_comb begin
      wd_cnt_d   = wd_cnt_q;
      wd_fault_d = wd_fault_q;
      if (!wd_idle || wd_trip) wd_cnt_d = '0;
      else if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + CNT_W'(1);
      if (arm_ok)  wd_fault_d = 1'b0;
      if (wd_trip) wd_fault_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt_q   <= '0;
         wd_fault_q <= 1'b0;
      end else begin
         wd_cnt_q   <= wd_cnt_d;
         wd_fault_q <= wd_fault_d;
      end
   end

   assign io_wdFault = wd_fault_q;
`else
   assign wd_trip = 1'b0;
`endif

   assign io_layerActive = active_vec;
   assign io_LayerEnd    = end_vec;
   assign io_LayerLast   = last_vec;
   assign io_overrun     = ovr_vec;
   assign io_busy        = enable;
   assign io_done        = done_q;

endmodule
